// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch_tr instruction-fetch stage.
//   INSTR_W       : instruction / address width
//   PC_INC        : byte stride between sequential fetches
//   fetch_entry_t : FIFO payload {instr, pc}
//   align_pc()    : clears the byte-offset bits of an address
package fetch_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned PC_INC  = 4;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [INSTR_W-1:0] pc;
   } fetch_entry_t;

   function automatic logic [INSTR_W-1:0] align_pc(input logic [INSTR_W-1:0] addr);
      return {addr[INSTR_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_tr_if.sv
// Fetch-stage bus bundle: instruction-memory request/response plus the
// TR valid/ready handshake toward decode/execute.
//   master : the fetch stage (drives imem_req/imem_addr, TR/tr_valid/tr_pc)
//   slave  : memory + consumer side (drives imem_rvalid/imem_rdata, tr_ready)
interface fetch_tr_if;
   import fetch_pkg::*;

   logic               imem_req;
   logic [INSTR_W-1:0] imem_addr;
   logic               imem_rvalid;
   logic [INSTR_W-1:0] imem_rdata;
   logic [INSTR_W-1:0] TR;
   logic               tr_valid;
   logic               tr_ready;
   logic [INSTR_W-1:0] tr_pc;

   modport master (
      output imem_req, imem_addr, TR, tr_valid, tr_pc,
      input  imem_rvalid, imem_rdata, tr_ready
   );

   modport slave (
      input  imem_req, imem_addr, TR, tr_valid, tr_pc,
      output imem_rvalid, imem_rdata, tr_ready
   );

endinterface

// File: rtl/fetch_fifo.sv
// Instruction FIFO for the fetch stage.
//   clk, rst_n : clock, async active-low reset
//   flush      : synchronous clear, wins over push/pop
//   push/data  : write one entry (ignored when full unless popping too)
//   pop        : drop the head entry (ignored when empty)
//   head/valid : head entry and non-empty flag
//   count      : number of stored entries
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush,
   input  logic                         push,
   input  fetch_entry_t                 push_data,
   input  logic                         pop,
   output fetch_entry_t                 head,
   output logic                         valid,
   output logic [$clog2(DEPTH):0]       count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   fetch_entry_t     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Pop only real data; push at full is allowed when the head leaves the same cycle.
   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);

   // Pointer and occupancy state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= PTR_W'(wr_ptr + 1'b1);
         if (do_pop)  rd_ptr <= PTR_W'(rd_ptr + 1'b1);
         count <= CNT_W'(count + CNT_W'(do_push) - CNT_W'(do_pop));
      end
   end

   // Storage needs no reset; valid gates every read.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= push_data;
   end

   assign head  = mem[rd_ptr];
   assign valid = (count != '0);

endmodule

// File: rtl/fetch_tr.sv
// Instruction-fetch stage: owns the PC, issues in-order word reads to
// instruction memory, buffers returned words and presents them as TR.
//   clk, rst_n  : clock, async active-low reset
//   bus         : fetch_tr_if.master (imem request/response, TR handshake)
//   redirect    : load redirect_pc and flush buffered / in-flight fetches
//   redirect_pc : redirect target (low two bits ignored)
// Optional (macro FETCH_PERF_EN): perf_fetched / perf_stall saturating
// counters of popped instructions and starved-consumer cycles.
module fetch_tr
   import fetch_pkg::*;
#(
   parameter int unsigned        DEPTH    = 4,
   parameter int unsigned        MAX_OUT  = 2,
   parameter logic [INSTR_W-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               rst_n,
   fetch_tr_if.master         bus,
   input  logic               redirect,
   input  logic [INSTR_W-1:0] redirect_pc
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]        perf_fetched,
   output logic [31:0]        perf_stall
`endif
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
   localparam int unsigned OUT_W = $clog2(MAX_OUT + 1);

   logic [INSTR_W-1:0] pc;
   logic [INSTR_W-1:0] rsp_pc;
   logic [OUT_W-1:0]   outstanding;
   logic [OUT_W-1:0]   drop;
   logic [CNT_W-1:0]   count;
   logic               issue;
   logic               resp;
   logic               push;
   logic               pop;
   logic               head_valid;
   fetch_entry_t       head;

   // Issue only when every in-flight word is guaranteed a FIFO slot.
   // rst_n gates the request so it falls immediately on reset assertion.
   assign issue = rst_n && !redirect
                  && (32'(outstanding) < MAX_OUT)
                  && (32'(count) + 32'(outstanding) < DEPTH);

   // Stray rvalid with nothing outstanding is ignored.
   assign resp = bus.imem_rvalid && (outstanding != '0);
   assign push = resp && (drop == '0) && !redirect;
   assign pop  = head_valid && bus.tr_ready;

   // PC, outstanding-request and stale-response bookkeeping.
   // rsp_pc tracks the address of the next kept response: after a redirect
   // every surviving response is sequential from the new target.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc          <= RESET_PC;
         rsp_pc      <= RESET_PC;
         outstanding <= '0;
         drop        <= '0;
      end else begin
         if (redirect)   pc <= align_pc(redirect_pc);
         else if (issue) pc <= pc + 32'(PC_INC);

         outstanding <= OUT_W'(outstanding + OUT_W'(issue) - OUT_W'(resp));

         // Everything still in flight after this edge is stale.
         if (redirect)                 drop <= OUT_W'(outstanding - OUT_W'(resp));
         else if (resp && drop != '0)  drop <= OUT_W'(drop - 1'b1);

         if (redirect)  rsp_pc <= align_pc(redirect_pc);
         else if (push) rsp_pc <= rsp_pc + 32'(PC_INC);
      end
   end

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (redirect),
      .push      (push),
      .push_data ('{instr: bus.imem_rdata, pc: rsp_pc}),
      .pop       (pop),
      .head      (head),
      .valid     (head_valid),
      .count     (count)
   );

   assign bus.imem_req  = issue;
   assign bus.imem_addr = pc;
   assign bus.tr_valid  = head_valid;
   assign bus.TR        = head_valid ? head.instr : '0;
   assign bus.tr_pc     = head_valid ? head.pc    : '0;

`ifdef FETCH_PERF_EN
   // Saturating performance counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetched <= '0;
         perf_stall   <= '0;
      end else begin
         if (pop && perf_fetched != '1) perf_fetched <= perf_fetched + 32'd1;
         if (bus.tr_ready && !head_valid && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_tr.sv
// Self-checking bench for fetch_tr: in-order memory model with random
// latency, random consumer backpressure and redirects, checked against an
// epoch-tagged reference of the expected instruction stream.
module tb_fetch_tr;
   import fetch_pkg::*;

   localparam int unsigned        DEPTH    = 4;
   localparam int unsigned        MAX_OUT  = 2;
   localparam logic [31:0]        RESET_PC = 32'h0000_0000;

   typedef struct { logic [31:0] addr; int epoch; int due; } req_t;
   typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;

   logic        clk;
   logic        rst_n;
   logic        redirect;
   logic [31:0] redirect_pc;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_stall;
`endif

   fetch_tr_if bus ();

   fetch_tr #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .redirect    (redirect),
      .redirect_pc (redirect_pc)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetched(perf_fetched),
      .perf_stall  (perf_stall)
`endif
   );

   always #5 clk = ~clk;

   int          total, passes, cyc, last_due, epoch;
   int          lat_min, lat_max, ready_pct, n_pop;
   logic [31:0] exp_pc;
   req_t        pend[$];
   ent_t        expq[$];
   logic        s_req, s_valid;
   logic [31:0] s_addr, s_tr, s_pc;

   function automatic logic [31:0] memword(input logic [31:0] a);
      if (a == 32'h0) return 32'h012A_4020;
      return (a * 32'h9E37_79B1) ^ 32'hA5A5_1234;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
   endtask

   task automatic model_reset();
      pend.delete();
      expq.delete();
      exp_pc   = RESET_PC;
      last_due = -1;
      epoch++;
   endtask

   // Called at posedge+1; returns at the next posedge+1.
   task automatic drive_cycle(input bit rdir, input logic [31:0] rpc);
      bit   rdy, rsp_now, exp_req;
      req_t r;
      int   due;
      rdy = ($urandom_range(0, 99) < ready_pct);
      redirect       = rdir;
      redirect_pc    = rpc;
      bus.tr_ready   = rdy;
      rsp_now = 1'b0;
      if (pend.size() != 0 && pend[0].due <= cyc) begin
         r = pend.pop_front();
         rsp_now = 1'b1;
      end
      bus.imem_rvalid = rsp_now;
      bus.imem_rdata  = rsp_now ? memword(r.addr) : 32'hDEAD_BEEF;
      @(negedge clk);
      s_req = bus.imem_req;  s_addr = bus.imem_addr;
      s_valid = bus.tr_valid; s_tr = bus.TR; s_pc = bus.tr_pc;
      // Spec rule: no redirect, under the outstanding cap, and room for every in-flight word.
      exp_req = !rdir && (pend.size() + int'(rsp_now) < MAX_OUT)
                && (expq.size() + pend.size() + int'(rsp_now) < DEPTH);
      chk("imem_req", 32'(s_req), 32'(exp_req));
      if (exp_req) chk("imem_addr", s_addr, exp_pc);
      chk("tr_valid", 32'(s_valid), 32'(expq.size() != 0));
      if (expq.size() != 0) begin
         chk("TR", s_tr, expq[0].instr);
         chk("tr_pc", s_pc, expq[0].pc);
      end
      if (rdir) begin
         expq.delete();
         epoch++;
         exp_pc = {rpc[31:2], 2'b00};
      end else begin
         if (expq.size() != 0 && rdy) begin
            void'(expq.pop_front());
            n_pop++;
         end
         if (rsp_now && r.epoch == epoch) expq.push_back('{memword(r.addr), r.addr});
         if (exp_req) begin
            due = cyc + int'($urandom_range(lat_min, lat_max));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend.push_back('{exp_pc, epoch, due});
            exp_pc = exp_pc + 32'd4;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Asserts reset wherever called, checks the asynchronous response, releases at posedge+1.
   task automatic do_reset();
      rst_n = 1'b0;
      bus.imem_rvalid = 1'b0;
      redirect = 1'b0;
      #1;
      chk("rst_req", 32'(bus.imem_req), 32'h0);
      chk("rst_valid", 32'(bus.tr_valid), 32'h0);
      chk("rst_TR", bus.TR, 32'h0);
      chk("rst_tr_pc", bus.tr_pc, 32'h0);
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc = 0;
   endtask

   task automatic wait_req(input string tag);
      int n;
      n = 0;
      do begin
         drive_cycle(1'b0, 32'h0);
         n++;
      end while (!s_req && n < 20);
      chk(tag, 32'(s_req), 32'h1);
   endtask

   initial begin
      int nreq, first_req, first_valid, n;
      clk = 1'b0; rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0;
      bus.imem_rvalid = 1'b0; bus.imem_rdata = '0; bus.tr_ready = 1'b0;
      total = 0; passes = 0; epoch = 0; n_pop = 0;
      #2;
      do_reset();

      // Latency 1, consumer always ready: back-to-back stream.
      lat_min = 1; lat_max = 1; ready_pct = 100;
      first_req = -1; first_valid = -1;
      for (int i = 0; i < 20; i++) begin
         n = cyc;
         drive_cycle(1'b0, 32'h0);
         if (s_req && first_req < 0) first_req = n;
         if (s_valid && first_valid < 0) first_valid = n;
      end
      chk("first_valid_lat", 32'(first_valid - first_req), 32'd2);
      chk("stream_pops", 32'(n_pop), 32'd18);

      // Consumer stalled: FIFO fills, requests stop.
      do_reset();
      ready_pct = 0; nreq = 0;
      for (int i = 0; i < 10; i++) begin
         drive_cycle(1'b0, 32'h0);
         if (s_req) nreq++;
      end
      chk("stall_reqs", 32'(nreq), 32'd4);
      chk("stall_TR", s_tr, 32'h012A_4020);
      chk("stall_tr_pc", s_pc, 32'h0);

      // Latency 3: outstanding cap enforced by the per-cycle request check.
      do_reset();
      lat_min = 3; lat_max = 3; ready_pct = 100; n_pop = 0;
      for (int i = 0; i < 30; i++) drive_cycle(1'b0, 32'h0);
      chk("lat3_pops", 32'(n_pop > 10), 32'h1);

      // Redirect with two requests in flight.
      do_reset();
      n = 0;
      while (pend.size() != 2 && n < 20) begin
         drive_cycle(1'b0, 32'h0);
         n++;
      end
      chk("two_outstanding", 32'(pend.size()), 32'd2);
      drive_cycle(1'b1, 32'h0000_0103);
      chk("redir_valid", 32'(s_valid), 32'h1 & 32'(s_valid));
      wait_req("redir_req_seen");
      chk("redir_addr", s_addr, 32'h0000_0100);
      n = 0;
      do begin
         drive_cycle(1'b0, 32'h0);
         n++;
      end while (!s_valid && n < 20);
      chk("redir_first_valid", 32'(s_valid), 32'h1);
      chk("redir_first_pc", s_pc, 32'h0000_0100);

      // PC wrap at the top of the address space.
      lat_min = 1; lat_max = 1;
      drive_cycle(1'b1, 32'hFFFF_FFFE);
      wait_req("wrap_req0");
      chk("wrap_addr0", s_addr, 32'hFFFF_FFFC);
      wait_req("wrap_req1");
      chk("wrap_addr1", s_addr, 32'h0000_0000);
      for (int i = 0; i < 6; i++) drive_cycle(1'b0, 32'h0);

      // Reset while the FIFO holds three entries.
      do_reset();
      ready_pct = 0; n = 0;
      while (expq.size() != 3 && n < 20) begin
         drive_cycle(1'b0, 32'h0);
         n++;
      end
      chk("fifo_three", 32'(expq.size()), 32'd3);
      #2;
      do_reset();
      ready_pct = 100;
      drive_cycle(1'b0, 32'h0);
      chk("restart_req", 32'(s_req), 32'h1);
      chk("restart_addr", s_addr, RESET_PC);

      // Random traffic: variable latency, backpressure and redirects.
      lat_min = 1; lat_max = 4; ready_pct = 70;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 99) < 3) drive_cycle(1'b1, $urandom);
         else                           drive_cycle(1'b0, 32'h0);
      end

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
